// File: rtl/round_sat_pkg.sv
// Shared types and constants for the round/saturate pipeline.
// Reserved round-mode code 3 is folded onto half-even when a sample is captured.
package round_sat_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2
  } round_mode_t;

  localparam logic [1:0]  RND_MODE_RESERVED = 2'd3;
  localparam round_mode_t RND_RESERVED_MAP  = RND_HALF_EVEN;
  localparam int          SAT_CNT_WIDTH     = 16;

  function automatic round_mode_t decode_mode(input logic [1:0] mode);
    if (mode == RND_MODE_RESERVED) return RND_RESERVED_MAP;
    return round_mode_t'(mode);
  endfunction

endpackage

// File: rtl/round_sat_clip.sv
// Combinational clipper: signed wide sum -> OUT_WIDTH two's complement value plus
// saturation flag. SUM_WIDTH must exceed OUT_WIDTH.
module round_sat_clip
  import round_sat_pkg::*;
#(
  parameter int SUM_WIDTH = 13,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [SUM_WIDTH-1:0] sum,
  output logic        [OUT_WIDTH-1:0] clip,
  output logic                        sat
);

  localparam logic signed [SUM_WIDTH-1:0] MAX_V =
    {{(SUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] MIN_V =
    {{(SUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    clip = sum[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (sum > MAX_V) begin
      clip = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (sum < MIN_V) begin
      clip = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/round_sat_pipe.sv
// Three-stage round/saturate pipe with bubble-collapsing valid/ready flow control.
// Optional saturation counter (sat_cnt/sat_clr) enabled by ROUND_SAT_STATS_EN.
module round_sat_pipe
  import round_sat_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int FRAC_BITS = 4,
  parameter int OUT_WIDTH = 8,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic [1:0]           mode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 sat_o
`ifdef ROUND_SAT_STATS_EN
  ,
  input  logic                     sat_clr,
  output logic [SAT_CNT_WIDTH-1:0] sat_cnt
`endif
);

  localparam int K_WIDTH   = IN_WIDTH - FRAC_BITS;
  localparam int SUM_WIDTH = K_WIDTH + 1;
  localparam logic [FRAC_BITS-1:0] STICKY_MASK = FRAC_BITS'((1 << (FRAC_BITS - 1)) - 1);

  logic                 v1, v2;
  logic [IN_WIDTH-1:0]  d1;
  logic [TAG_WIDTH-1:0] t1, t2;
  round_mode_t          m1;
  logic signed [SUM_WIDTH-1:0] s2;

  logic load1, load2, load3;
  logic signed [K_WIDTH-1:0]   k_val;
  logic                        guard, sticky, inc;
  logic signed [SUM_WIDTH-1:0] sum_next;
  logic [OUT_WIDTH-1:0]        clip_val;
  logic                        clip_sat;

  // Each stage refills whenever it is empty or its successor is taking its content.
  always_comb begin
    load3 = !valid_o || ready_i;
    load2 = !v2 || load3;
    load1 = !v1 || load2;
  end

  assign ready_o = load1 && !rst;

  // Arithmetic shift right by FRAC_BITS is just the upper bits taken as signed.
  always_comb begin
    k_val  = d1[IN_WIDTH-1:FRAC_BITS];
    guard  = d1[FRAC_BITS-1];
    sticky = |(d1[FRAC_BITS-1:0] & STICKY_MASK);
    case (m1)
      RND_TRUNC:   inc = 1'b0;
      RND_HALF_UP: inc = guard;
      default:     inc = guard && (sticky || k_val[0]);
    endcase
    sum_next = {k_val[K_WIDTH-1], k_val} + SUM_WIDTH'(inc);
  end

  round_sat_clip #(
    .SUM_WIDTH(SUM_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_clip (
    .sum  (s2),
    .clip (clip_val),
    .sat  (clip_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      d1      <= '0;
      t1      <= '0;
      m1      <= RND_TRUNC;
      v2      <= 1'b0;
      s2      <= '0;
      t2      <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      tag_o   <= '0;
      sat_o   <= 1'b0;
    end else begin
      if (load1) begin
        v1 <= valid_i;
        d1 <= data_i;
        t1 <= tag_i;
        m1 <= decode_mode(mode_i);
      end
      if (load2) begin
        v2 <= v1;
        s2 <= sum_next;
        t2 <= t1;
      end
      if (load3) begin
        valid_o <= v2;
        data_o  <= clip_val;
        tag_o   <= t2;
        sat_o   <= clip_sat;
      end
    end
  end

`ifdef ROUND_SAT_STATS_EN
  // Clear wins over a simultaneous count; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt <= '0;
    end else if (valid_o && ready_i && sat_o && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end
`endif

endmodule
